mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single-port data memory behind `MEMSTAGE`. It shares the RAM between the pipeline MEM stage (port A, priority) and a loader/debug port (port B, starvation-bounded). Each access is registered into a one-cycle RAM command slot, and read data is returned with a valid pulse. It sits between the EX/MEM pipeline register and `MEMSTAGE`, and drives `Mem_WrEn`, `ALU_MEM_Addr` and `MEM_DataIn`.

## Interface
- `MAX_WAIT`, default 4: number of consecutive lost arbitrations after which port B wins the next one (1..15).
- `clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `a_req`, `b_req` input 1: request; held high until the matching grant.
- `a_we`, `b_we` input 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` input 32: byte address; bits [1:0] must be 00.
- `a_wdata`, `b_wdata` input 32: write data.
- `a_gnt`, `b_gnt` output 1: combinational one-cycle grant; the request is accepted in that cycle.
- `a_stall` output 1: `a_req & ~a_gnt`; freezes the pipeline.
- `a_rvalid`, `b_rvalid` output 1: one-cycle pulse; `*_rdata` is valid.
- `a_rdata`, `b_rdata` output 32: registered read data; holds until the next read on that port.
- `a_err`, `b_err` output 1: one-cycle pulse alongside `rvalid` when the accepted request was misaligned.
- `Mem_WrEn` output 1: RAM write enable.
- `ALU_MEM_Addr` output 32: RAM address, forwarded unmodified from the latched request.
- `MEM_DataIn` output 32: RAM write data.
- `MEM_DataOut` input 32: RAM read data, combinational from `ALU_MEM_Addr`.

## Operation
- **FSM states: IDLE, BUSY.**
  - IDLE with any request: grant one port. The edge latches owner, we, addr and wdata into the command registers and moves to BUSY.
  - BUSY always returns to IDLE after one cycle. No grants are issued in BUSY.
- **Arbitration in IDLE:**
  - Port A wins unless `b_req` is high and `wait_cnt == MAX_WAIT`; in that case B wins.
  - If only one port requests, it wins.
- **`wait_cnt` (4-bit, saturating at `MAX_WAIT`):**
  - Increments on each IDLE cycle with `b_req & ~b_gnt`.
  - Clears on `b_gnt`.
  - Holds in BUSY and when `b_req` is low.
- **RAM drive:**
  - In BUSY, `ALU_MEM_Addr` = latched addr, `MEM_DataIn` = latched wdata, and `Mem_WrEn` = latched we & aligned.
  - In IDLE, `Mem_WrEn` = 0 and addr/data hold their last values.
- **Read completion:** at the end-of-BUSY edge, the owner's `rdata` captures `MEM_DataOut` and its `rvalid` pulses in the following cycle.
- **Write completion:**
  - The RAM commits at the end-of-BUSY edge.
  - No `rvalid` is produced unless the request was misaligned.
- **Misaligned request** (addr[1:0] ≠ 00):
  - Granted normally, but `Mem_WrEn` stays 0.
  - `rvalid` and `err` both pulse for the owner, and `rdata` is loaded with 0.
  - This applies to both reads and writes.
- **Reset (asynchronous, `Reset` = 0):**
  - State = IDLE, `wait_cnt` = 0, all command registers = 0, `Mem_WrEn` = 0 immediately.
  - `rvalid`/`err` = 0; both `rdata` = 0.
  - Reset asserted during BUSY aborts the access; no write commits and no `rvalid` is produced.

## Timing
- **Read latency:** grant in cycle t, RAM accessed in cycle t+1, `rvalid` in cycle t+2.
- **Throughput:** one access per 2 cycles.
  - A new grant can occur in cycle t+2, concurrent with the previous `rvalid`.
  - `a_stall` is high for a held `a_req` throughout BUSY.
- **Simultaneous events:**
  - `rvalid` for one port and a grant to the other in the same cycle is legal.
  - Both requests with `wait_cnt < MAX_WAIT`: A is granted and `wait_cnt` increments.
- **Worst-case B latency:** B waits at most `MAX_WAIT` lost arbitrations, i.e. `2*MAX_WAIT` cycles, before its grant.

## Test plan
- **Reset values:** apply `Reset` = 0 mid-BUSY on an A write of 0x1F to 0x4 → `Mem_WrEn` drops at once; a later read of 0x4 does not return 0x1F (if previously 0, it returns 0); all outputs are 0 during reset.
- **Basic write/read:** A writes 0x1F to 0x4, then reads 0x4 → `a_gnt` pulses; `Mem_WrEn` = 1 for exactly one cycle; `a_rvalid` arrives 2 cycles after the read grant with `a_rdata` = 0x0000001F.
- **Fairness:** A and B request continuously, `MAX_WAIT` = 4 → B is granted on the 5th arbitration, then `wait_cnt` = 0 and A wins the following round; `a_stall` is high during B's slot.
- **Misaligned access:** B writes 0x10 to 0x1 → `b_gnt` pulses, `Mem_WrEn` stays 0, `b_err` and `b_rvalid` pulse with `b_rdata` = 0; a subsequent read of 0x0 is unchanged.
- **Back-to-back traffic:** B reads 0xFC0 while A's request arrives in B's `rvalid` cycle → `b_rvalid` and `a_gnt` occur in the same cycle; neither `rdata` is corrupted.
- **Single requester:** only `b_req` high, B reads 0x4 → granted immediately with `wait_cnt` 0; data is returned at t+2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response signals of ports A and B plus the RAM-side bus of mem_arbiter
// slave  : arbiter view (takes requests and RAM read data, drives grants, responses and RAM command)
// master : requester/RAM view (drives requests and RAM read data, observes everything else)
interface mem_arbiter_if;
  logic a_req, b_req, a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic a_gnt, b_gnt, a_stall;
  logic a_rvalid, b_rvalid, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic Mem_WrEn;
  logic [31:0] ALU_MEM_Addr, MEM_DataIn, MEM_DataOut;
  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, MEM_DataOut,
    output a_gnt, b_gnt, a_stall, a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata,
           Mem_WrEn, ALU_MEM_Addr, MEM_DataIn
  );
  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, MEM_DataOut,
    input  a_gnt, b_gnt, a_stall, a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata,
           Mem_WrEn, ALU_MEM_Addr, MEM_DataIn
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer sharing one single-port data RAM (A priority, B starvation-bounded)
// clk   : rising-edge clock
// Reset : asynchronous active-low reset
// bus   : mem_arbiter_if.slave -- port A/B requests, grants, read responses, RAM command and read data
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input logic clk,
  input logic Reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} arbState;
  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);
  arbState state, stateNext;
  logic [3:0] waitCnt;
  logic cmdOwner, cmdWe;
  logic [31:0] cmdAddr, cmdWdata;
  logic idle, waitFull, bWins, aGnt, bGnt, cmdMisaligned, done;
  logic aRvalid, bRvalid, aErr, bErr;
  logic [31:0] aRdata, bRdata;
  always_comb begin
    idle = state == IDLE;
    waitFull = waitCnt == WaitMax;
    bWins = bus.b_req & (~bus.a_req | waitFull);
    bGnt = idle & bWins;
    aGnt = idle & bus.a_req & ~bWins;
    stateNext = (idle & (bus.a_req | bus.b_req)) ? BUSY : IDLE;
    cmdMisaligned = cmdAddr[1:0] != 2'b00;
    // reads and every misaligned access produce a response at the end of BUSY
    done = ~idle & (cmdMisaligned | ~cmdWe);
  end
  assign bus.a_gnt = aGnt;
  assign bus.b_gnt = bGnt;
  assign bus.a_stall = bus.a_req & ~aGnt;
  assign bus.Mem_WrEn = ~idle & cmdWe & ~cmdMisaligned;
  assign bus.ALU_MEM_Addr = cmdAddr;
  assign bus.MEM_DataIn = cmdWdata;
  assign bus.a_rvalid = aRvalid;
  assign bus.b_rvalid = bRvalid;
  assign bus.a_err = aErr;
  assign bus.b_err = bErr;
  assign bus.a_rdata = aRdata;
  assign bus.b_rdata = bRdata;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) waitCnt <= '0;
    else if (bGnt) waitCnt <= '0;
    else if (idle & bus.b_req & ~waitFull) waitCnt <= waitCnt + 4'd1;
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      cmdOwner <= 1'b0;
      cmdWe <= 1'b0;
      cmdAddr <= '0;
      cmdWdata <= '0;
    end else if (aGnt | bGnt) begin
      cmdOwner <= bGnt;
      cmdWe <= bGnt ? bus.b_we : bus.a_we;
      cmdAddr <= bGnt ? bus.b_addr : bus.a_addr;
      cmdWdata <= bGnt ? bus.b_wdata : bus.a_wdata;
    end
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      aRvalid <= 1'b0;
      bRvalid <= 1'b0;
      aErr <= 1'b0;
      bErr <= 1'b0;
      aRdata <= '0;
      bRdata <= '0;
    end else begin
      aRvalid <= done & ~cmdOwner;
      bRvalid <= done & cmdOwner;
      aErr <= done & ~cmdOwner & cmdMisaligned;
      bErr <= done & cmdOwner & cmdMisaligned;
      if (done & ~cmdOwner) aRdata <= cmdMisaligned ? '0 : bus.MEM_DataOut;
      if (done & cmdOwner) bRdata <= cmdMisaligned ? '0 : bus.MEM_DataOut;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a RAM model and read-response scoreboard
module tb_mem_arbiter;
  typedef struct {logic [31:0] data; logic err;} expT;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic initDone = 1'b0;
  logic [31:0] ram [0:1023];
  logic [31:0] modelMem [0:1023];
  expT aQ[$], bQ[$];
  expT aE, bE;
  int checks = 0, passes = 0, fails = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.MAX_WAIT(4)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.MEM_DataOut = ram[bus.ALU_MEM_Addr[11:2]];
  always @(posedge clk)
    if (!initDone) begin
      for (int i = 0; i < 1024; i++) ram[i] <= (i == 1008) ? 32'hCAFE0FC0 : 32'h0;
      initDone <= 1'b1;
    end else if (bus.Mem_WrEn) ram[bus.ALU_MEM_Addr[11:2]] <= bus.MEM_DataIn;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.a_rvalid) begin
      if (aQ.size() == 0) check("a_rvalid unexpected", 1, 0);
      else begin
        aE = aQ.pop_front();
        check("sb a_rdata", bus.a_rdata, aE.data);
        check("sb a_err", bus.a_err, aE.err);
      end
    end else if (bus.a_err) check("a_err without rvalid", 1, 0);
    if (bus.b_rvalid) begin
      if (bQ.size() == 0) check("b_rvalid unexpected", 1, 0);
      else begin
        bE = bQ.pop_front();
        check("sb b_rdata", bus.b_rdata, bE.data);
        check("sb b_err", bus.b_err, bE.err);
      end
    end else if (bus.b_err) check("b_err without rvalid", 1, 0);
  end
  task automatic access(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit otherValid);
    logic mis;
    expT e;
    mis = addr[1:0] != 2'b00;
    @(negedge clk);
    if (p) begin
      bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    #1;
    check(p ? "b_gnt" : "a_gnt", p ? bus.b_gnt : bus.a_gnt, 1);
    check(p ? "a_rvalid with grant" : "b_rvalid with grant", p ? bus.a_rvalid : bus.b_rvalid, otherValid);
    if (mis || !we) begin
      e.data = mis ? 32'h0 : modelMem[addr[11:2]];
      e.err = mis;
      if (p) bQ.push_back(e);
      else aQ.push_back(e);
    end
    @(negedge clk);
    if (p) bus.b_req = 0;
    else bus.a_req = 0;
    #1;
    check("busy Mem_WrEn", bus.Mem_WrEn, we & ~mis);
    check("busy ALU_MEM_Addr", bus.ALU_MEM_Addr, addr);
    if (we) check("busy MEM_DataIn", bus.MEM_DataIn, wdata);
    if (we && !mis) modelMem[addr[11:2]] = wdata;
  endtask
  task automatic pulse(input bit p, input bit exp);
    @(negedge clk);
    #1;
    check(p ? "b_rvalid" : "a_rvalid", p ? bus.b_rvalid : bus.a_rvalid, exp);
    check("idle Mem_WrEn", bus.Mem_WrEn, 0);
  endtask
  initial begin
    bit prevB;
    for (int i = 0; i < 1024; i++) modelMem[i] = (i == 1008) ? 32'hCAFE0FC0 : 32'h0;
    bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
    bus.a_addr = 0; bus.b_addr = 0; bus.a_wdata = 0; bus.b_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst a_gnt", bus.a_gnt, 0);
    check("rst b_gnt", bus.b_gnt, 0);
    check("rst a_stall", bus.a_stall, 0);
    check("rst rvalids", {bus.a_rvalid, bus.b_rvalid, bus.a_err, bus.b_err}, 0);
    check("rst a_rdata", bus.a_rdata, 0);
    check("rst b_rdata", bus.b_rdata, 0);
    check("rst Mem_WrEn", bus.Mem_WrEn, 0);
    check("rst ALU_MEM_Addr", bus.ALU_MEM_Addr, 0);
    check("rst MEM_DataIn", bus.MEM_DataIn, 0);
    Reset = 1;
    // A write 0x1F to 0x4 aborted by reset in the middle of BUSY
    @(negedge clk);
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h4; bus.a_wdata = 32'h1F;
    #1 check("abort a_gnt", bus.a_gnt, 1);
    @(negedge clk);
    bus.a_req = 0;
    #1 check("abort busy Mem_WrEn", bus.Mem_WrEn, 1);
    Reset = 0;
    #1;
    check("abort Mem_WrEn drops", bus.Mem_WrEn, 0);
    check("abort ALU_MEM_Addr", bus.ALU_MEM_Addr, 0);
    check("abort MEM_DataIn", bus.MEM_DataIn, 0);
    @(negedge clk);
    #1 check("abort a_rvalid in reset", bus.a_rvalid, 0);
    Reset = 1;
    @(negedge clk);
    #1 check("abort a_rvalid after", bus.a_rvalid, 0);
    access(0, 0, 32'h4, 0, 0);
    pulse(0, 1);
    // basic write/read on A
    access(0, 1, 32'h4, 32'h1F, 0);
    pulse(0, 0);
    access(0, 0, 32'h4, 0, 0);
    pulse(0, 1);
    check("basic a_rdata", bus.a_rdata, 32'h1F);
    // misaligned write on B, then aligned read of 0x0 unchanged
    access(1, 1, 32'h1, 32'h10, 0);
    pulse(1, 1);
    check("mis b_err", bus.b_err, 1);
    check("mis b_rdata", bus.b_rdata, 0);
    access(1, 0, 32'h0, 0, 0);
    pulse(1, 1);
    // back-to-back: A granted in B's rvalid cycle
    access(1, 0, 32'hFC0, 0, 0);
    access(0, 0, 32'h4, 0, 1);
    check("b2b b_rdata", bus.b_rdata, 32'hCAFE0FC0);
    pulse(0, 1);
    check("b2b a_rdata", bus.a_rdata, 32'h1F);
    check("b2b b_rdata held", bus.b_rdata, 32'hCAFE0FC0);
    // single requester B
    access(1, 0, 32'h4, 0, 0);
    pulse(1, 1);
    check("single b_rdata", bus.b_rdata, 32'h1F);
    // fairness: both request continuously
    bus.a_we = 0; bus.a_addr = 32'h4; bus.b_we = 0; bus.b_addr = 32'hFC0;
    prevB = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.a_req = i < 6;
      bus.b_req = 1;
      #1;
      check("fair a_gnt", bus.a_gnt, i != 4 && i != 6);
      check("fair b_gnt", bus.b_gnt, i == 4 || i == 6);
      if (i == 4) check("fair a_stall lost", bus.a_stall, 1);
      if (i > 0) check(prevB ? "fair b_rvalid" : "fair a_rvalid", prevB ? bus.b_rvalid : bus.a_rvalid, 1);
      prevB = i == 4 || i == 6;
      if (prevB) bQ.push_back('{32'hCAFE0FC0, 1'b0});
      else aQ.push_back('{32'h1F, 1'b0});
      @(negedge clk);
      if (i == 5) bus.a_req = 0;
      if (i == 6) bus.b_req = 0;
      #1;
      if (i < 5) check("fair a_stall busy", bus.a_stall, 1);
      check("fair no grant in busy", {bus.a_gnt, bus.b_gnt}, 0);
    end
    pulse(1, 1);
    repeat (2) @(negedge clk);
    #3;
    check("aQ drained", aQ.size(), 0);
    check("bQ drained", bQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
